// File: rtl/nram_fifo_ctrl.sv
// nram_fifo_ctrl: four-entry valid/ready FIFO controller driving an external 4x8 NRAM
module nram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [WIDTH-1:0] io_mem_D,
  output logic [1:0]       io_mem_WADD,
  output logic             io_mem_WE,
  output logic [1:0]       io_mem_RADD,
  input  logic [WIDTH-1:0] io_mem_Q,
  output logic [2:0]       io_count,
  output logic [2:0]       io_hwm
);
  localparam logic [2:0] FULL = 3'(DEPTH);
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] count_q, count_d, hwm_q, hwm_d;
  logic enq_fire, deq_fire;
  always_comb begin
    io_enq_ready = !reset && count_q != FULL;
    io_deq_valid = !reset && count_q != 3'd0;
    enq_fire = io_enq_valid && io_enq_ready;
    deq_fire = io_deq_valid && io_deq_ready;
    wptr_d = enq_fire ? wptr_q + 2'd1 : wptr_q;
    rptr_d = deq_fire ? rptr_q + 2'd1 : rptr_q;
    count_d = count_q + {2'b0, enq_fire} - {2'b0, deq_fire};
    hwm_d = count_d > hwm_q ? count_d : hwm_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      hwm_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      hwm_q <= hwm_d;
    end
  end
  assign io_deq_bits = io_mem_Q;
  assign io_mem_D = io_enq_bits;
  assign io_mem_WADD = wptr_q;
  assign io_mem_WE = enq_fire;
  assign io_mem_RADD = rptr_q;
  assign io_count = count_q;
  assign io_hwm = hwm_q;
endmodule

// File: doc/nram_fifo_ctrl.md
# nram_fifo_ctrl

Four-entry FIFO controller that sits directly upstream of the team's 4×8 NRAM mux/register file. It owns the write/read pointers and occupancy, and presents a valid/ready enqueue port and a valid/ready dequeue port to the surrounding datapath. It drives the memory's write data, write address and read address, and returns the memory's combinational read data as dequeue data. Storage lives entirely in the downstream memory; this block holds only pointers, counters and status.

## Interface
- WIDTH, 8: data width; matches the memory data ports.
- DEPTH, 4: entries; fixed to the memory size, so pointers are 2 bits.

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_enq_valid  in  1  producer offers io_enq_bits
- io_enq_ready  out  1  controller accepts an enqueue this cycle
- io_enq_bits  in  8  enqueue data
- io_deq_valid  out  1  io_deq_bits holds the oldest entry
- io_deq_ready  in  1  consumer takes the entry this cycle
- io_deq_bits  out  8  dequeue data, combinationally equal to io_mem_Q
- io_mem_D  out  8  memory write data, combinationally equal to io_enq_bits
- io_mem_WADD  out  2  memory write address, equal to wptr
- io_mem_WE  out  1  memory write enable, high only on an enqueue fire
- io_mem_RADD  out  2  memory read address, equal to rptr
- io_mem_Q  in  8  memory read data; combinational on io_mem_RADD
- io_count  out  3  current occupancy, 0..4
- io_hwm  out  3  high-water mark: maximum io_count since reset

## Operation
- State: wptr[1:0], rptr[1:0], count[2:0], hwm[2:0]. All are registered.
- Derived status:
  - EMPTY when count==0.
  - FULL when count==4.
  - PARTIAL otherwise.
- io_enq_ready = !reset && count!=4.
- io_deq_valid = !reset && count!=0.
- enq_fire = io_enq_valid && io_enq_ready. deq_fire = io_deq_valid && io_deq_ready.
- io_mem_WE = enq_fire.
- On enq_fire: wptr <= wptr+1, mod 4 wrap, so 3 -> 0.
- On deq_fire: rptr <= rptr+1, mod 4 wrap.
- count update:
  - count+1 on enq_fire only.
  - count-1 on deq_fire only.
  - Unchanged when both fire or neither fires.
- hwm <= max(hwm, next count). hwm is never decremented except by reset.
- No bypass: data enqueued into an empty FIFO is not visible on the same cycle.
- Full with deq_fire: enqueue is still refused that cycle, because io_enq_ready is already 0.
- Empty: io_deq_ready is ignored.
- Any io_enq_valid or io_deq_ready while not ready/valid is ignored and leaves all state unchanged.
- count never exceeds 4 and never underflows. Both are structurally impossible given the ready/valid gating.

## Timing
- Reset, sampled on a rising edge with reset=1: wptr=rptr=0, count=0, hwm=0.
- While reset is high:
  - io_enq_ready=0, io_deq_valid=0, io_mem_WE=0.
  - io_mem_WADD=0 and io_mem_RADD=0 from the cycle after the first reset edge.
  - io_count=0, io_hwm=0.
- First cycle after reset deasserts: io_enq_ready=1.
- Reset mid-operation: contents are abandoned, and pointers and counters return to zero on that edge. Memory contents are not cleared and are unobservable.
- Enqueue-to-dequeue latency is 1 cycle: an enq_fire at edge N makes io_deq_valid=1 and io_deq_bits equal to that data during cycle N+1.
- Dequeue: io_deq_bits is valid in the same cycle as io_deq_valid. The entry is consumed at the edge where deq_fire=1.
- Throughput is one enqueue and one dequeue per cycle when PARTIAL.
- io_count and io_hwm update on the edge of the fire, so they are visible the following cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold reset 2 cycles, then release.
  - Required: io_enq_ready=0 and io_deq_valid=0 during reset. After release, io_enq_ready=1, io_deq_valid=0, io_count=0, io_hwm=0, io_mem_WE=0.
- Fill to full:
  - Stimulus: enqueue 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles with io_deq_ready=0.
  - Required: io_mem_WADD steps 0,1,2,3 with WE=1. Then io_count=4, io_enq_ready=0, io_hwm=4. A fifth enqueue of 0x55 produces WE=0.
- Drain in order:
  - Stimulus: from full, hold io_deq_ready=1 for 4 cycles.
  - Required: io_deq_bits 0x11, 0x22, 0x33, 0x44 with RADD 0..3. Then io_deq_valid=0, io_count=0, io_hwm still 4.
- Wrap-around and streaming:
  - Stimulus: enqueue 0xA0..0xA9 while dequeuing each one a cycle later.
  - Required: io_count stays 1. Pointers wrap 3 -> 0 at least twice. Output order is 0xA0..0xA9 with no loss.
- Simultaneous enqueue and dequeue at boundaries:
  - Full with deq_fire: enqueue is refused and count goes 4 -> 3.
  - Empty with io_deq_ready=1 and enqueue 0x7E: no dequeue occurs that cycle; next cycle io_deq_bits=0x7E.
- Reset mid-stream:
  - Stimulus: with io_count=3, assert reset for 1 cycle.
  - Required: next cycle io_count=0, io_deq_valid=0, RADD=WADD=0, io_hwm=0.
